// File: rtl/fetch_ctrl_if.sv
// Instruction-fetch bus bundle: redirect input, instruction-memory request/response,
// and the IF/ID slot handed to decode. Signal suffixes are from the fetch unit's view.
interface fetch_ctrl_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        id_ready_i;

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with a one-entry IF/ID slot.
// Redirects squash the slot and, if a request is in flight, discard its response.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    fetch_ctrl_if.master  bus
);
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] req_pc_q,   req_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic slot_free;
    logic imem_req;

    // A new request is only issued when the slot is guaranteed free by the time data returns.
    assign slot_free = !if_valid_q || bus.id_ready_i;
    assign imem_req  = (state_q == ST_REQ) && slot_free;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        if (if_valid_q && bus.id_ready_i) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (imem_req && bus.imem_gnt_i) begin
                    req_pc_d = pc_q;
                    state_d  = bus.redirect_i ? ST_KILL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    state_d = ST_REQ;
                    if (!bus.redirect_i) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = bus.imem_rdata_i;
                        pc_d       = pc_q + 32'd4;
                    end
                end else if (bus.redirect_i) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                if (bus.imem_rvalid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect wins over a same-cycle response or consume.
        if (bus.redirect_i) begin
            pc_d       = {bus.redirect_pc_i[31:2], 2'b00};
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign bus.imem_req_o  = imem_req;
    assign bus.imem_addr_o = pc_q;
    assign bus.if_valid_o  = if_valid_q;
    assign bus.if_pc_o     = if_pc_q;
    assign bus.if_instr_o  = if_instr_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a responder returns data one cycle after each grant,
// and a second instance checks the wrap from RESET_PC=FFFF_FFFC.
module tb_fetch_ctrl;
    logic clk_i;
    logic rst_ni;
    logic auto_rsp;
    int   n_tests;
    int   n_fail;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus2 ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus2)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %08h", tag, got);
        end
    endtask

    // One clock: memories answer a request granted in this cycle during the next one.
    task automatic tick();
        logic        g1, g2;
        logic [31:0] a1, a2;
        g1 = bus.imem_req_o && bus.imem_gnt_i;
        a1 = bus.imem_addr_o;
        g2 = bus2.imem_req_o && bus2.imem_gnt_i;
        a2 = bus2.imem_addr_o;
        @(posedge clk_i);
        #1;
        if (auto_rsp) begin
            bus.imem_rvalid_i = g1;
            bus.imem_rdata_i  = instr_of(a1);
        end
        bus2.imem_rvalid_i = g2;
        bus2.imem_rdata_i  = instr_of(a2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        clk_i    = 1'b0;
        rst_ni   = 1'b0;
        auto_rsp = 1'b1;
        bus.redirect_i     = 1'b0;
        bus.redirect_pc_i  = 32'h0;
        bus.imem_gnt_i     = 1'b0;
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i   = 32'h0;
        bus.id_ready_i     = 1'b1;
        bus2.redirect_i    = 1'b0;
        bus2.redirect_pc_i = 32'h0;
        bus2.imem_gnt_i    = 1'b0;
        bus2.imem_rvalid_i = 1'b0;
        bus2.imem_rdata_i  = 32'h0;
        bus2.id_ready_i    = 1'b1;

        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_valid", {31'h0, bus.if_valid_o}, 32'h0);
        check_val("rst_if_pc", bus.if_pc_o, 32'h0);
        check_val("rst_instr", bus.if_instr_o, 32'h0);
        check_val("rst_addr", bus.imem_addr_o, 32'h0);
        check_val("rst_addr_wrap", bus2.imem_addr_o, 32'hFFFF_FFFC);

        rst_ni = 1'b1;
        bus.imem_gnt_i  = 1'b1;
        bus2.imem_gnt_i = 1'b1;
        #1;
        check_val("first_req", {31'h0, bus.imem_req_o}, 32'h1);
        check_val("first_addr", bus.imem_addr_o, 32'h0);

        // Streaming: one instruction every two cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("stream_gap_valid", {31'h0, bus.if_valid_o}, 32'h0);
            check_val("stream_wait_req", {31'h0, bus.imem_req_o}, 32'h0);
            tick();
            check_val("stream_valid", {31'h0, bus.if_valid_o}, 32'h1);
            check_val("stream_pc", bus.if_pc_o, 32'(4 * i));
            check_val("stream_instr", bus.if_instr_o, instr_of(32'(4 * i)));
            if (i == 0) begin
                check_val("wrap_pc0", bus2.if_pc_o, 32'hFFFF_FFFC);
                check_val("wrap_valid0", {31'h0, bus2.if_valid_o}, 32'h1);
            end
            if (i == 1) begin
                check_val("wrap_pc1", bus2.if_pc_o, 32'h0000_0000);
                check_val("wrap_instr1", bus2.if_instr_o, instr_of(32'h0));
            end
        end

        // Decode stall holds the slot and blocks new requests.
        bus.id_ready_i = 1'b0;
        #1;
        check_val("stall_req", {31'h0, bus.imem_req_o}, 32'h0);
        repeat (5) begin
            tick();
            check_val("stall_req", {31'h0, bus.imem_req_o}, 32'h0);
            check_val("stall_pc", bus.if_pc_o, 32'h0000_000C);
            check_val("stall_instr", bus.if_instr_o, instr_of(32'h0000_000C));
        end
        bus.id_ready_i = 1'b1;
        #1;
        check_val("unstall_req", {31'h0, bus.imem_req_o}, 32'h1);
        check_val("unstall_addr", bus.imem_addr_o, 32'h0000_0010);
        tick();
        check_val("unstall_consumed", {31'h0, bus.if_valid_o}, 32'h0);
        tick();
        check_val("unstall_pc", bus.if_pc_o, 32'h0000_0010);

        // Redirect while waiting: response is discarded via KILL.
        auto_rsp = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        tick();
        check_val("wait_req", {31'h0, bus.imem_req_o}, 32'h0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        tick();
        bus.redirect_i = 1'b0;
        #1;
        check_val("kill_valid", {31'h0, bus.if_valid_o}, 32'h0);
        check_val("kill_req", {31'h0, bus.imem_req_o}, 32'h0);
        check_val("kill_addr", bus.imem_addr_o, 32'h0000_0100);
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid_i = 1'b0;
        #1;
        check_val("killed_valid", {31'h0, bus.if_valid_o}, 32'h0);
        check_val("killed_req", {31'h0, bus.imem_req_o}, 32'h1);
        check_val("killed_addr", bus.imem_addr_o, 32'h0000_0100);
        auto_rsp = 1'b1;
        tick();
        tick();
        check_val("redir_pc", bus.if_pc_o, 32'h0000_0100);
        check_val("redir_instr", bus.if_instr_o, instr_of(32'h0000_0100));

        // Redirect in the same cycle as the response: data dropped, straight back to REQ.
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0200;
        tick();
        bus.redirect_i = 1'b0;
        #1;
        check_val("drop_valid", {31'h0, bus.if_valid_o}, 32'h0);
        check_val("drop_req", {31'h0, bus.imem_req_o}, 32'h1);
        check_val("drop_addr", bus.imem_addr_o, 32'h0000_0200);
        tick();
        tick();
        check_val("drop_next_pc", bus.if_pc_o, 32'h0000_0200);

        // Redirect with a same-cycle grant: granted request becomes stale.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0302;
        tick();
        bus.redirect_i = 1'b0;
        #1;
        check_val("gnt_redir_req", {31'h0, bus.imem_req_o}, 32'h0);
        check_val("gnt_redir_addr", bus.imem_addr_o, 32'h0000_0300);
        tick();
        check_val("gnt_redir_valid", {31'h0, bus.if_valid_o}, 32'h0);
        check_val("gnt_redir_req2", {31'h0, bus.imem_req_o}, 32'h1);
        check_val("gnt_redir_addr2", bus.imem_addr_o, 32'h0000_0300);

        // Grant withheld: request and address stay put.
        bus.imem_gnt_i = 1'b0;
        repeat (4) begin
            tick();
            check_val("nognt_req", {31'h0, bus.imem_req_o}, 32'h1);
            check_val("nognt_addr", bus.imem_addr_o, 32'h0000_0300);
        end
        bus.imem_gnt_i = 1'b1;
        tick();

        // Asynchronous reset in WAIT, then a late response that must be ignored.
        auto_rsp = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("arst_addr", bus.imem_addr_o, 32'h0);
        check_val("arst_if_pc", bus.if_pc_o, 32'h0);
        check_val("arst_instr", bus.if_instr_o, 32'h0);
        check_val("arst_valid", {31'h0, bus.if_valid_o}, 32'h0);
        check_val("arst_req", {31'h0, bus.imem_req_o}, 32'h1);
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        #1;
        rst_ni = 1'b1;
        tick();
        check_val("late_rvalid_req", {31'h0, bus.imem_req_o}, 32'h1);
        check_val("late_rvalid_addr", bus.imem_addr_o, 32'h0);
        check_val("late_rvalid_valid", {31'h0, bus.if_valid_o}, 32'h0);
        bus.imem_rvalid_i = 1'b0;
        bus.imem_gnt_i    = 1'b1;
        auto_rsp = 1'b1;
        tick();
        tick();
        check_val("post_rst_valid", {31'h0, bus.if_valid_o}, 32'h1);
        check_val("post_rst_pc", bus.if_pc_o, 32'h0);
        check_val("post_rst_instr", bus.if_instr_o, instr_of(32'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 redirect_i  input  1  branch/jump taken; load redirect_pc_i as next fetch PC.
REQ-005 redirect_pc_i  input  32  redirect target; bits[1:0] ignored and forced to 2'b00.
REQ-006 imem_req_o  output  1  instruction memory request valid.
REQ-007 imem_addr_o  output  32  request address; equals current PC register pc_q.
REQ-008 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid_i  input  1  read data valid; at most one per granted request, at least 1 cycle after grant.
REQ-010 imem_rdata_i  input  32  instruction word.
REQ-011 if_valid_o  output  1  IF/ID slot holds a valid instruction.
REQ-012 if_pc_o  output  32  PC of the instruction in the slot.
REQ-013 if_instr_o  output  32  instruction in the slot.
REQ-014 id_ready_i  input  1  decode consumes the slot when if_valid_o && id_ready_i.

Function
REQ-015 State machine: REQ (issue fetch), WAIT (one request outstanding), KILL (outstanding response to be discarded); at most one outstanding request ever.
REQ-016 slot_free = !if_valid_o || id_ready_i; imem_req_o = (state==REQ) && slot_free.
REQ-017 REQ: on imem_req_o && imem_gnt_i, latch pc_q into req_pc and go to WAIT; otherwise stay in REQ with imem_addr_o stable.
REQ-018 WAIT: on imem_rvalid_i, load if_instr_o <= imem_rdata_i, if_pc_o <= req_pc, if_valid_o <= 1, pc_q <= pc_q + 4 (32-bit modulo, 32'hFFFF_FFFC wraps to 0), and go to REQ.
REQ-019 The slot is never overwritten while valid and unconsumed; REQ-016 guarantees it is free when the response arrives.
REQ-020 Consumption without a refill clears if_valid_o on the next edge.
REQ-021 Redirect, any state: pc_q <= {redirect_pc_i[31:2],2'b00}, if_valid_o <= 0; redirect has priority over a same-cycle response and a same-cycle consume.
REQ-022 Redirect in REQ without grant -> stay in REQ; new address appears on the next cycle.
REQ-023 Redirect in REQ with same-cycle grant -> go to KILL, since the granted request is stale.
REQ-024 Redirect in WAIT without rvalid -> go to KILL; with same-cycle rvalid -> discard data, go to REQ.
REQ-025 KILL: on imem_rvalid_i, discard data, leave pc_q unchanged, go to REQ; further redirects in KILL update pc_q only.
REQ-026 Latency: grant at cycle N, rvalid at N+1 -> if_valid_o high at N+2; peak throughput is 1 instruction per 2 cycles.
REQ-027 imem_rvalid_i received in REQ is ignored (protocol violation, no state change).

Reset
REQ-028 While rst_ni=0: pc_q=RESET_PC, state=REQ, if_valid_o=0, if_pc_o=0, if_instr_o=0, req_pc=0.
REQ-029 Reset asserted mid-WAIT drops the outstanding request; a late rvalid after release is ignored per REQ-027.
REQ-030 The first cycle after rst_ni rises asserts imem_req_o with imem_addr_o=RESET_PC.

Verification
REQ-031 Reset release, gnt=1, rvalid one cycle after each grant, id_ready=1 -> if_pc_o sequence 0,4,8,C, each valid 1 cycle in 2, instr matches memory.
REQ-032 id_ready=0 for 5 cycles with slot full -> imem_req_o=0, if_pc_o/if_instr_o held; ready=1 -> request issued same cycle.
REQ-033 Redirect to 32'h0000_0103 while in WAIT -> next response discarded, if_valid_o=0, next imem_addr_o=32'h0000_0100.
REQ-034 Redirect with same-cycle rvalid -> data dropped, imem_addr_o=target next cycle, no KILL state entered.
REQ-035 RESET_PC=32'hFFFF_FFFC -> fetches at FFFF_FFFC then 0000_0000.
REQ-036 gnt held low 4 cycles -> imem_req_o and imem_addr_o stable throughout; rst_ni low mid-WAIT -> all outputs at reset values asynchronously.
